// File: rtl/ps2_rx_ctrl_if.sv
// ps2_rx_ctrl_if -- register bus between a host and the PS/2 receiver.
//   req_i          : one-cycle access request
//   write_enable_i : 1 = write, 0 = read
//   addr_i         : byte address (low 8 bits decoded by the receiver)
//   write_data_i   : write data
//   read_data_o    : registered read data
//   ready_o        : request delayed by one cycle
// Signal names keep the receiver's port naming so the map to the block's
// pin list is one-to-one. The master modport is the host side, and the
// slave modport is the receiver side.
interface ps2_rx_ctrl_if;
    logic        req_i;
    logic        write_enable_i;
    logic [31:0] addr_i;
    logic [31:0] write_data_i;
    logic [31:0] read_data_o;
    logic        ready_o;

    modport master (
        output req_i,
        output write_enable_i,
        output addr_i,
        output write_data_i,
        input  read_data_o,
        input  ready_o
    );

    modport slave (
        input  req_i,
        input  write_enable_i,
        input  addr_i,
        input  write_data_i,
        output read_data_o,
        output ready_o
    );
endinterface

// File: rtl/ps2_rx_ctrl.sv
// ps2_rx_ctrl -- PS/2 keyboard receiver that feeds a byte FIFO and exposes
// it through a small register block.
//   clk_i   : sole clock, rising edge
//   rst_i   : synchronous active-high reset
//   kclk_i  : raw PS/2 clock (asynchronous, idles high)
//   kdata_i : raw PS/2 data (asynchronous, idles high)
//   bus     : register access port (ps2_rx_ctrl_if.slave)
//   irq_o   : level interrupt, FIFO non-empty and irq_en set
// Register map (addr[7:0]):
//   0x00 DATA   (R)  head byte, popped on read; 0 when empty
//   0x04 STATUS (R)  {overflow, frame_err, parity_err, 0, count[4:0]}
//   0x08 CTRL   (RW) bit0 irq_en, bit1 clear flags, bit2 flush FIFO
module ps2_rx_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         kclk_i,
    input  logic         kdata_i,
    ps2_rx_ctrl_if.slave bus,
    output logic         irq_o
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [4:0]      COUNT_FULL = 5'(FIFO_DEPTH);
    localparam logic [WD_W-1:0] WD_LIMIT   = WD_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    localparam logic [7:0] ADDR_DATA   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h04;
    localparam logic [7:0] ADDR_CTRL   = 8'h08;

    // ------------------------------------------------------------------
    // Input synchronizers: line 0 = kclk, line 1 = kdata. Both reset to the
    // idle-high level so a reset never fabricates a falling edge.
    // ------------------------------------------------------------------
    logic [1:0] line_raw;
    logic [1:0] line_sync;
    assign line_raw = {kdata_i, kclk_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                end else begin
                    meta_reg <= line_raw[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign line_sync[gi] = sync_reg;
        end
    endgenerate

    logic kclk_sync;
    logic kdata_sync;
    logic kclk_last_reg;
    logic kclk_fall;
    assign kclk_sync  = line_sync[0];
    assign kdata_sync = line_sync[1];
    assign kclk_fall  = kclk_last_reg & ~kclk_sync;

    always_ff @(posedge clk_i) begin
        if (rst_i) kclk_last_reg <= 1'b1;
        else       kclk_last_reg <= kclk_sync;
    end

    // ------------------------------------------------------------------
    // Frame FSM and watchdog
    // ------------------------------------------------------------------
    logic [1:0]      state_reg, state_next;
    logic [2:0]      bit_cnt_reg, bit_cnt_next;
    logic [7:0]      shift_reg, shift_next;
    logic            parity_bit_reg, parity_bit_next;
    logic [WD_W-1:0] wd_reg, wd_next;
    logic            frame_done;
    logic            timeout;

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        parity_bit_next = parity_bit_reg;
        wd_next         = wd_reg;
        frame_done      = 1'b0;
        timeout         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (kclk_fall && !kdata_sync) begin
                    state_next   = DATA;
                    bit_cnt_next = 3'd0;
                end
            end
            DATA: begin
                if (kclk_fall) begin
                    shift_next[bit_cnt_reg] = kdata_sync;
                    bit_cnt_next            = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) state_next = PARITY;
                end
            end
            PARITY: begin
                if (kclk_fall) begin
                    parity_bit_next = kdata_sync;
                    state_next      = STOP;
                end
            end
            default: begin
                if (kclk_fall) begin
                    state_next = IDLE;
                    frame_done = 1'b1;
                end
            end
        endcase

        // The watchdog only runs while a frame is in flight; a falling edge
        // restarts it and expiry abandons the partial byte.
        if (state_reg == IDLE) begin
            wd_next = '0;
        end else if (kclk_fall) begin
            wd_next = '0;
        end else if (wd_reg == WD_LIMIT) begin
            timeout    = 1'b1;
            state_next = IDLE;
            wd_next    = '0;
        end else begin
            wd_next = wd_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= 3'd0;
            shift_reg      <= 8'h00;
            parity_bit_reg <= 1'b0;
            wd_reg         <= '0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            parity_bit_reg <= parity_bit_next;
            wd_reg         <= wd_next;
        end
    end

    // Frame verdict at the stop edge. A bad stop bit outranks bad parity.
    logic parity_ok;
    logic frame_evt;
    logic parity_evt;
    assign parity_ok  = ^{shift_reg, parity_bit_reg};
    assign frame_evt  = (frame_done & ~kdata_sync) | timeout;
    assign parity_evt = frame_done & kdata_sync & ~parity_ok;

    // Good bytes are staged one cycle so the FIFO write lands in the cycle
    // after the stop edge.
    logic       push_req_reg;
    logic [7:0] push_data_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            push_req_reg  <= 1'b0;
            push_data_reg <= 8'h00;
        end else begin
            push_req_reg  <= frame_done & kdata_sync & parity_ok;
            push_data_reg <= shift_reg;
        end
    end

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [7:0] addr_lo;
    logic       rd_access;
    logic       ctrl_wr;
    logic       flag_clear;
    logic       fifo_flush;
    assign addr_lo    = bus.addr_i[7:0];
    assign rd_access  = bus.req_i & ~bus.write_enable_i;
    assign ctrl_wr    = bus.req_i & bus.write_enable_i & (addr_lo == ADDR_CTRL);
    assign flag_clear = ctrl_wr & bus.write_data_i[1];
    assign fifo_flush = ctrl_wr & bus.write_data_i[2];

    logic unused_bits;
    assign unused_bits = ^{bus.addr_i[31:8], bus.write_data_i[31:3]};

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [4:0]       count_reg;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             push_ok;
    logic             overflow_evt;

    assign fifo_full  = (count_reg == COUNT_FULL);
    assign fifo_empty = (count_reg == 5'd0);
    assign pop        = rd_access & (addr_lo == ADDR_DATA) & ~fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok      = push_req_reg & (~fifo_full | pop) & ~fifo_flush;
    assign overflow_evt = push_req_reg & fifo_full & ~pop & ~fifo_flush;

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr_reg] <= push_data_reg;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || fifo_flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= 5'd0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 5'd1;
                2'b01:   count_reg <= count_reg - 5'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control and sticky status flags. An event in the same cycle as a
    // clear wins, so no error is ever lost.
    // ------------------------------------------------------------------
    logic irq_en_reg;
    logic overflow_reg;
    logic frame_err_reg;
    logic parity_err_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_en_reg     <= 1'b0;
            overflow_reg   <= 1'b0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en_reg <= bus.write_data_i[0];
            overflow_reg   <= (overflow_reg   & ~flag_clear) | overflow_evt;
            frame_err_reg  <= (frame_err_reg  & ~flag_clear) | frame_evt;
            parity_err_reg <= (parity_err_reg & ~flag_clear) | parity_evt;
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [31:0] status_word;
    logic [31:0] read_mux;
    logic [31:0] read_data_reg;
    logic        ready_reg;

    assign status_word = {23'h0, overflow_reg, frame_err_reg, parity_err_reg,
                          1'b0, count_reg};

    always_comb begin
        read_mux = 32'h0;
        case (addr_lo)
            ADDR_DATA:   read_mux = fifo_empty ? 32'h0 : {24'h0, mem[rd_ptr_reg]};
            ADDR_STATUS: read_mux = status_word;
            ADDR_CTRL:   read_mux = {31'h0, irq_en_reg};
            default:     read_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            read_data_reg <= 32'h0;
            ready_reg     <= 1'b0;
        end else begin
            if (rd_access) read_data_reg <= read_mux;
            ready_reg <= bus.req_i;
        end
    end

    assign bus.read_data_o = read_data_reg;
    assign bus.ready_o     = ready_reg;
    assign irq_o           = irq_en_reg & ~fifo_empty;
endmodule

// File: tb/tb_ps2_rx_ctrl.sv
`timescale 1ns/1ps
module tb_ps2_rx_ctrl;
    localparam int DEPTH = 4;
    localparam int HALF  = 20;   // kclk half period in clk cycles

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic kclk = 1'b1;
    logic kdata = 1'b1;
    logic irq;

    ps2_rx_ctrl_if bus_if();

    ps2_rx_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(2000)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .kclk_i  (kclk),
        .kdata_i (kdata),
        .bus     (bus_if),
        .irq_o   (irq)
    );

    always #50 clk = ~clk;   // 10 MHz

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];    // scoreboard: bytes expected from DATA reads
    logic [31:0] rd;

    // Expected results are queued when a frame is driven
    task automatic model_push(input logic [7:0] b);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        bus_if.req_i          = 1'b1;
        bus_if.write_enable_i = 1'b0;
        bus_if.addr_i         = {24'h0, a};
        @(negedge clk);
        bus_if.req_i = 1'b0;
        d = bus_if.read_data_o;
        $display("read  addr=%02h data=%08h", a, d);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        bus_if.req_i          = 1'b1;
        bus_if.write_enable_i = 1'b1;
        bus_if.addr_i         = {24'h0, a};
        bus_if.write_data_i   = d;
        @(negedge clk);
        bus_if.req_i          = 1'b0;
        bus_if.write_enable_i = 1'b0;
        $display("write addr=%02h data=%08h", a, d);
    endtask

    task automatic ps2_bit(input logic v);
        kdata = v;
        repeat (HALF) @(negedge clk);
        kclk = 1'b0;
        repeat (HALF) @(negedge clk);
        kclk = 1'b1;
    endtask

    // Sends one frame. With read_at_push set, a DATA read is issued so that
    // it lands on the FIFO write cycle of this frame's byte.
    task automatic send_frame(input logic [7:0] b, input logic bad_par,
                              input logic read_at_push, output logic [31:0] d);
        logic par;
        par = (~^b) ^ bad_par;
        d = 32'h0;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        kdata = 1'b1;
        repeat (HALF) @(negedge clk);
        kclk = 1'b0;
        if (read_at_push) begin
            repeat (3) @(negedge clk);
            bus_if.req_i          = 1'b1;
            bus_if.write_enable_i = 1'b0;
            bus_if.addr_i         = 32'h0;
            @(negedge clk);
            bus_if.req_i = 1'b0;
            d = bus_if.read_data_o;
            repeat (HALF - 4) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        kclk = 1'b1;
        repeat (4) @(negedge clk);
        $display("frame byte=%02h bad_parity=%0b read_at_push=%0b", b, bad_par, read_at_push);
    endtask

    task automatic test_reset();
        checks++;
        if (bus_if.read_data_o !== 32'h0) begin
            errors++; $display("FAIL reset_read_data actual=%08h required=00000000", bus_if.read_data_o);
        end
        checks++;
        if (bus_if.ready_o !== 1'b0) begin
            errors++; $display("FAIL reset_ready actual=%0b required=0", bus_if.ready_o);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL reset_irq actual=%0b required=0", irq);
        end
        bus_read(8'h04, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL reset_status actual=%08h required=00000000", rd);
        end
        bus_read(8'h08, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL reset_ctrl actual=%08h required=00000000", rd);
        end
    endtask

    task automatic test_good_frame();
        logic [31:0] expv;
        bus_write(8'h08, 32'h1);
        send_frame(8'h16, 1'b0, 1'b0, rd);
        model_push(8'h16);
        bus_read(8'h04, rd);
        checks++;
        if (rd !== 32'h001) begin
            errors++; $display("FAIL good_status actual=%08h required=00000001", rd);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL good_irq actual=%0b required=1", irq);
        end
        bus_read(8'h00, rd);
        expv = (exp_q.size() > 0) ? {24'h0, exp_q.pop_front()} : 32'h0;
        checks++;
        if (rd !== expv) begin
            errors++; $display("FAIL good_data actual=%08h required=%08h", rd, expv);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL good_irq_after_read actual=%0b required=0", irq);
        end
        bus_read(8'h04, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL good_status_after_read actual=%08h required=00000000", rd);
        end
    endtask

    task automatic test_parity_error();
        send_frame(8'h16, 1'b1, 1'b0, rd);
        bus_read(8'h04, rd);
        checks++;
        if (rd !== 32'h040) begin
            errors++; $display("FAIL parity_status actual=%08h required=00000040", rd);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL parity_irq actual=%0b required=0", irq);
        end
        bus_write(8'h08, 32'h2);
        bus_read(8'h04, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL parity_clear actual=%08h required=00000000", rd);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] expv;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b0, 1'b0, rd);
            model_push(8'(i));
        end
        bus_read(8'h04, rd);
        checks++;
        if (rd !== 32'h104) begin
            errors++; $display("FAIL overflow_status actual=%08h required=00000104", rd);
        end
        for (int i = 0; i < 5; i++) begin
            bus_read(8'h00, rd);
            expv = (exp_q.size() > 0) ? {24'h0, exp_q.pop_front()} : 32'h0;
            checks++;
            if (rd !== expv) begin
                errors++; $display("FAIL overflow_read%0d actual=%08h required=%08h", i, rd, expv);
            end
        end
        bus_write(8'h08, 32'h2);
    endtask

    task automatic test_timeout();
        logic [7:0] b;
        logic [31:0] expv;
        b = 8'h1C;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(b[i]);
        kdata = 1'b1;
        repeat (1880) @(negedge clk);
        bus_read(8'h04, rd);
        checks++;
        if (rd !== 32'h000) begin
            errors++; $display("FAIL timeout_early actual=%08h required=00000000", rd);
        end
        repeat (200) @(negedge clk);
        bus_read(8'h04, rd);
        checks++;
        if (rd !== 32'h080) begin
            errors++; $display("FAIL timeout_flag actual=%08h required=00000080", rd);
        end
        bus_write(8'h08, 32'h2);
        send_frame(8'h1C, 1'b0, 1'b0, rd);
        model_push(8'h1C);
        bus_read(8'h00, rd);
        expv = (exp_q.size() > 0) ? {24'h0, exp_q.pop_front()} : 32'h0;
        checks++;
        if (rd !== expv) begin
            errors++; $display("FAIL timeout_next_frame actual=%08h required=%08h", rd, expv);
        end
    endtask

    task automatic test_regmap();
        bus_write(8'h08, 32'h1);
        checks++;
        if (bus_if.ready_o !== 1'b1) begin
            errors++; $display("FAIL ready_after_write actual=%0b required=1", bus_if.ready_o);
        end
        @(negedge clk);
        checks++;
        if (bus_if.ready_o !== 1'b0) begin
            errors++; $display("FAIL ready_idle actual=%0b required=0", bus_if.ready_o);
        end
        bus_write(8'h0C, 32'hFFFF_FFFF);
        bus_read(8'h08, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++; $display("FAIL ctrl_readback actual=%08h required=00000001", rd);
        end
        bus_read(8'h0C, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL unmapped_read actual=%08h required=00000000", rd);
        end
        send_frame(8'h5A, 1'b0, 1'b0, rd);
        model_push(8'h5A);
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL flush_irq_before actual=%0b required=1", irq);
        end
        bus_write(8'h08, 32'h5);
        exp_q.delete();
        bus_read(8'h04, rd);
        checks++;
        if (rd !== {27'h0, 5'(exp_q.size())}) begin
            errors++; $display("FAIL flush_status actual=%08h required=%08h", rd, exp_q.size());
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL flush_irq_after actual=%0b required=0", irq);
        end
        bus_write(8'h08, 32'h0);
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        logic [31:0] expv;
        b = 8'hB7;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(b[i]);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        kdata = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h29, 1'b0, 1'b0, rd);
        model_push(8'h29);
        bus_read(8'h04, rd);
        checks++;
        if (rd !== 32'h001) begin
            errors++; $display("FAIL midreset_status actual=%08h required=00000001", rd);
        end
        bus_read(8'h00, rd);
        expv = (exp_q.size() > 0) ? {24'h0, exp_q.pop_front()} : 32'h0;
        checks++;
        if (rd !== expv) begin
            errors++; $display("FAIL midreset_data actual=%08h required=%08h", rd, expv);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] expv;
        for (int i = 0; i < 4; i++) begin
            send_frame(8'h11 + 8'(i), 1'b0, 1'b0, rd);
            model_push(8'h11 + 8'(i));
        end
        bus_read(8'h04, rd);
        checks++;
        if (rd !== 32'h004) begin
            errors++; $display("FAIL b2b_full_status actual=%08h required=00000004", rd);
        end
        // Read coinciding with the push: the model pops first, then pushes.
        send_frame(8'h15, 1'b0, 1'b1, rd);
        expv = (exp_q.size() > 0) ? {24'h0, exp_q.pop_front()} : 32'h0;
        model_push(8'h15);
        checks++;
        if (rd !== expv) begin
            errors++; $display("FAIL b2b_push_read actual=%08h required=%08h", rd, expv);
        end
        bus_read(8'h04, rd);
        checks++;
        if (rd !== 32'h004) begin
            errors++; $display("FAIL b2b_status actual=%08h required=00000004", rd);
        end
        for (int i = 0; i < 4; i++) begin
            bus_read(8'h00, rd);
            expv = (exp_q.size() > 0) ? {24'h0, exp_q.pop_front()} : 32'h0;
            checks++;
            if (rd !== expv) begin
                errors++; $display("FAIL b2b_drain%0d actual=%08h required=%08h", i, rd, expv);
            end
        end
    endtask

    initial begin
        bus_if.req_i          = 1'b0;
        bus_if.write_enable_i = 1'b0;
        bus_if.addr_i         = 32'h0;
        bus_if.write_data_i   = 32'h0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_good_frame();
        test_parity_error();
        test_overflow();
        test_timeout();
        test_regmap();
        test_reset_midframe();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
